pipeline_input_feeder: RTL and testbench

//  - Stall-aware input buffer directly upstream of one pipeline_top input port (pipeline1/2_inputs, in_valid_x).
//  - Absorbs producer words into a small FIFO and presents them to the pipeline.
//  - Holds the presented word while the pipeline's out_stall is high.
//  - Honours flush by discarding all buffered and presented words. One instance per pipeline.

---
 rtl/pipeline_input_feeder.sv | 158 +++++++++++++++
 tb/tb_pipeline_input_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_input_feeder.sv
// Stall-aware input buffer feeding one pipeline input port: a DEPTH-entry FIFO plus a registered output stage.
// Optional statistics counters (stall_cycles, flushed_words) are enabled by defining FEEDER_STATS_EN.
module pipeline_input_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        up_data,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic                     flush,
    input  logic                     stall,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]              stall_cycles,
    output logic [15:0]              flushed_words
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic w_up_ready;
    logic w_push;
    logic w_load;
    logic w_pop;
    logic w_bypass;
    logic w_wr_en;

    // Ready depends only on state and flush so the producer never sees a valid->ready loop.
    assign w_up_ready = reset && !flush && (r_level < FULL_LVL);

    // Decide what the output stage takes this edge: FIFO head first, then bypass, else go idle.
    always_comb begin
        w_push   = up_valid && w_up_ready;
        w_load   = !r_out_valid || !stall;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (w_load) begin
            if (r_level != {LVL_W{1'b0}}) begin
                w_pop = 1'b1;
            end else if (w_push) begin
                w_bypass = 1'b1;
            end else begin
                w_pop    = 1'b0;
                w_bypass = 1'b0;
            end
        end else begin
            w_pop    = 1'b0;
            w_bypass = 1'b0;
        end
        w_wr_en = w_push && !w_bypass;
    end

    // FIFO storage; contents are don't-care once pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= up_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Output register: holds while stalled, flush discards the presented word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_pop) begin
                r_out_data  <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
            end else if (w_bypass) begin
                r_out_data  <= up_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign up_ready  = w_up_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign level     = r_level;

`ifdef FEEDER_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flushed_words;
    logic [16:0] w_flush_sum;

    function automatic logic [15:0] sat16(input logic [16:0] value);
        if (value[16]) begin
            return 16'hFFFF;
        end else begin
            return value[15:0];
        end
    endfunction

    assign w_flush_sum = {1'b0, r_flushed_words} + 17'(r_level) + 17'(r_out_valid);

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles  <= 16'h0000;
            r_flushed_words <= 16'h0000;
        end else begin
            if (r_out_valid && stall) begin
                r_stall_cycles <= sat16({1'b0, r_stall_cycles} + 17'h00001);
            end
            if (flush) begin
                r_flushed_words <= sat16(w_flush_sum);
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign flushed_words = r_flushed_words;
`endif

endmodule

// File: tb/tb_pipeline_input_feeder.sv
// Scoreboard bench for pipeline_input_feeder: accepted words are queued and matched against consumed outputs.
module tb_pipeline_input_feeder;

    logic        clk;
    logic        reset;
    logic [31:0] up_data;
    logic        up_valid;
    logic        up_ready;
    logic        flush;
    logic        stall;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
`ifdef FEEDER_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flushed_words;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] q[$];

    pipeline_input_feeder #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .flush(flush), .stall(stall), .out_data(out_data), .out_valid(out_valid), .level(level)
`ifdef FEEDER_STATS_EN
        , .stall_cycles(stall_cycles), .flushed_words(flushed_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step: score the consumed word, record an accepted word, then advance past the edge.
    task automatic tick();
        logic [31:0] exp;
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && !stall) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h with no word expected", out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) begin
                        failures++;
                        $display("FAIL sb_order: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (up_valid && up_ready) q.push_back(up_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        up_valid = 1'b0;
        stall    = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (q.size() == 0 && !out_valid) break;
            tick();
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: pending=%0d out_valid=%b expected 0 and 0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", out_data); end
        if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (up_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", up_ready); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        stall = 1'b0; up_valid = 1'b1; up_data = 32'hA5A5_0001;
        tick();
        up_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid: got %b expected 1", out_valid); end
        if (out_data !== 32'hA5A5_0001) begin failures++; $display("FAIL lat_data: got %h expected a5a50001", out_data); end
        if (level !== 3'd0) begin failures++; $display("FAIL lat_level: got %0d expected 0", level); end
        drain();
    endtask

    task automatic test_stall_fill();
        stall = 1'b1; up_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            up_data = 32'(i);
            tick();
        end
        up_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: got %b expected 1", out_valid); end
        if (out_data !== 32'd1) begin failures++; $display("FAIL fill_hold: got %h expected 1", out_data); end
        if (level !== 3'd4) begin failures++; $display("FAIL fill_level: got %0d expected 4", level); end
        if (up_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b expected 0", up_ready); end
        stall = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
                failures++;
                $display("FAIL fill_seq: got %h/%b expected %h/1", out_data, out_valid, 32'(k));
            end
        end
        drain();
    endtask

    task automatic test_toggle();
        logic [31:0] next_word;
        logic        acc;
        next_word = 32'h0000_0100;
        up_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall   = (i % 2 == 0);
            up_data = next_word;
            acc     = up_ready;
            tick();
            if (acc) next_word = next_word + 32'd1;
            checks++;
            if (level > 3'd4) begin failures++; $display("FAIL toggle_level: got %0d expected <=4", level); end
        end
        drain();
    endtask

    task automatic test_flush();
        stall = 1'b1; up_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_data = 32'h0000_00F0 + 32'(i);
            tick();
        end
        up_valid = 1'b0;
        checks += 2;
        if (level !== 3'd4) begin failures++; $display("FAIL flush_pre_level: got %0d expected 4", level); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        if (level !== 3'd0) begin failures++; $display("FAIL flush_level: got %0d expected 0", level); end
        if (up_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", up_ready); end
`ifdef FEEDER_STATS_EN
        checks++;
        if (flushed_words !== 16'd5) begin failures++; $display("FAIL flushed_words: got %0d expected 5", flushed_words); end
`endif
        drain();
    endtask

    task automatic test_async_reset();
        stall = 1'b0; up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_data = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        #3;
        reset = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        if (level !== 3'd0) begin failures++; $display("FAIL areset_level: got %0d expected 0", level); end
        if (up_ready !== 1'b0) begin failures++; $display("FAIL areset_ready: got %b expected 0", up_ready); end
        q.delete();
        up_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        up_valid = 1'b1; up_data = 32'hBEEF_0002;
        tick();
        up_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_lat_valid: got %b expected 1", out_valid); end
        if (out_data !== 32'hBEEF_0002) begin failures++; $display("FAIL areset_lat_data: got %h expected beef0002", out_data); end
        drain();
    endtask

`ifdef FEEDER_STATS_EN
    task automatic test_stats_saturate();
        stall = 1'b1; up_valid = 1'b1; up_data = 32'h5A5A_0003;
        tick();
        up_valid = 1'b0;
        checks++;
        if (flushed_words !== 16'd0) begin failures++; $display("FAIL stats_flush_reset: got %0d expected 0", flushed_words); end
        repeat (70000) @(posedge clk);
        #1;
        checks += 2;
        if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL stall_sat: got %h expected ffff", stall_cycles); end
        if (out_data !== 32'h5A5A_0003 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stats_hold: got %h/%b expected 5a5a0003/1", out_data, out_valid);
        end
        drain();
    endtask
`endif

    initial begin
        reset = 1'b0; up_data = 32'h0; up_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        #12;
        test_reset();
        test_latency();
        test_stall_fill();
        test_toggle();
        test_flush();
        test_async_reset();
`ifdef FEEDER_STATS_EN
        test_stats_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
